// File: rtl/mem_lvs_pkg.sv
// Shared definitions for the backing-store responder and the L1 that talks to it:
// responder state encoding, line width and the offset/index fields of an address.
package mem_lvs_pkg;

  localparam int LINE_W   = 64;
  localparam int OFF_MSB  = 2;
  localparam int OFF_LSB  = 0;
  localparam int IDX_MSB  = 9;
  localparam int IDX_LSB  = 3;
  localparam int IDX_BITS = IDX_MSB - IDX_LSB + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_DONE = 3'd2,
    WR_WAIT = 3'd3,
    WR_DONE = 3'd4
  } lvs_state_e;

  function automatic int idx_width(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/mem_lvs_array.sv
// Line store behind the responder: one registered write port, one asynchronous read port.
// Contents are never touched by reset.
module mem_lvs_array
  import mem_lvs_pkg::*;
#(
  parameter int LINES = 128,
  parameter int IDXW  = 7
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDXW-1:0]   waddr_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic [IDXW-1:0]   raddr_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [LINES] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_lvs_responder.sv
// Fixed-latency backing-store responder for the L1: accepts one fill or write in IDLE,
// completes it LAT edges later with a one-cycle pulse.
//
//   state   | meaning
//   IDLE    | waiting for pedirData; request captured on the accepting edge
//   RD_WAIT | fill in flight, latency counter running
//   RD_DONE | dataComplete pulse, dataIn holds the fetched line
//   WR_WAIT | write in flight, latency counter running
//   WR_DONE | writeComplete pulse, store written on the edge leaving this state
module mem_lvs_responder
  import mem_lvs_pkg::*;
#(
  parameter int TamAddr = 16,
  parameter int LAT     = 4,
  parameter int LINES   = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pedirData,
  input  logic               wr_mem,
  input  logic [TamAddr-1:0] address_lvs,
  input  logic [LINE_W-1:0]  data_write,
  output logic [LINE_W-1:0]  dataIn,
  output logic               dataComplete,
  output logic               writeComplete,
  output logic               busy
);

  localparam int IDXW = idx_width(LINES);

  lvs_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] data_in_q, data_in_d;
  logic [LINE_W-1:0] rdata;
  logic [IDXW-1:0]   line_sel;
  logic              unused_addr;

  // Offset bits and everything above the index field only alias lines.
  assign unused_addr = ^address_lvs;
  assign line_sel    = IDXW'(int'(address_lvs[IDX_MSB:IDX_LSB]) % LINES);

  mem_lvs_array #(
    .LINES (LINES),
    .IDXW  (IDXW)
  ) u_array (
    .clk     (clk),
    .we_i    (state_q == WR_DONE),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_q),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      data_in_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      data_in_q <= data_in_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    data_in_d = data_in_q;
    case (state_q)
      IDLE: begin
        if (pedirData) begin
          idx_d   = line_sel;
          wdata_d = data_write;
          cnt_d   = 4'(LAT - 1);
          state_d = wr_mem ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = RD_DONE;
          data_in_d = rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = WR_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_DONE: state_d = IDLE;
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dataIn        = data_in_q;
  assign dataComplete  = (state_q == RD_DONE);
  assign writeComplete = (state_q == WR_DONE);
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_lvs_responder.sv
// Bench for mem_lvs_responder: a LAT=4 and a LAT=1 instance checked against a
// line-array model with fixed completion timing.
module tb_mem_lvs_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ped  [2];
  logic        wr   [2];
  logic [15:0] addr [2];
  logic [63:0] wdat [2];
  logic [63:0] din  [2];
  logic        dc   [2];
  logic        wc   [2];
  logic        bsy  [2];

  int          tests = 0;
  int          fails = 0;
  logic [63:0] mdl     [2][128];
  logic [63:0] last_rd [2];

  always #5 clk = ~clk;

  mem_lvs_responder #(.TamAddr(16), .LAT(4), .LINES(128)) dut (
    .clk(clk), .rst(rst), .pedirData(ped[0]), .wr_mem(wr[0]), .address_lvs(addr[0]),
    .data_write(wdat[0]), .dataIn(din[0]), .dataComplete(dc[0]),
    .writeComplete(wc[0]), .busy(bsy[0]));

  mem_lvs_responder #(.TamAddr(16), .LAT(1), .LINES(128)) dut1 (
    .clk(clk), .rst(rst), .pedirData(ped[1]), .wr_mem(wr[1]), .address_lvs(addr[1]),
    .data_write(wdat[1]), .dataIn(din[1]), .dataComplete(dc[1]),
    .writeComplete(wc[1]), .busy(bsy[1]));

  function automatic int lat_of(input int s);
    return (s == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request; inputs are scrambled right after acceptance to prove they are ignored.
  task automatic txn(input int s, input bit w, input logic [15:0] a, input logic [63:0] d);
    int idx;
    int lat;
    idx = (int'(a) >> 3) % 128;
    lat = lat_of(s);
    @(negedge clk);
    ped[s] = 1'b1; wr[s] = w; addr[s] = a; wdat[s] = d;
    @(posedge clk); #1;
    ped[s] = 1'b0; wr[s] = ~w; addr[s] = 16'($urandom); wdat[s] = {$urandom, $urandom};
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk); #1;
      if (k == lat && !w) last_rd[s] = mdl[s][idx];
      chk($sformatf("busy s%0d k%0d", s, k), 64'(bsy[s]), 64'(k != lat + 1));
      chk($sformatf("dataComplete s%0d k%0d", s, k), 64'(dc[s]), 64'(k == lat && !w));
      chk($sformatf("writeComplete s%0d k%0d", s, k), 64'(wc[s]), 64'(k == lat && w));
      chk($sformatf("dataIn s%0d k%0d", s, k), din[s], last_rd[s]);
    end
    if (w) mdl[s][idx] = d;
  endtask

  initial begin
    logic [63:0] d;
    logic [15:0] a;
    for (int s = 0; s < 2; s++) begin
      ped[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wdat[s] = '0; last_rd[s] = '0;
      for (int i = 0; i < 128; i++) mdl[s][i] = '0;
    end
    rst = 1'b0;
    #12;
    for (int s = 0; s < 2; s++) begin
      chk("reset dataIn", din[s], 64'h0);
      chk("reset dataComplete", 64'(dc[s]), 64'h0);
      chk("reset writeComplete", 64'(wc[s]), 64'h0);
      chk("reset busy", 64'(bsy[s]), 64'h0);
    end
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 128; i++) txn(0, 1'b1, 16'(i << 3), {$urandom, $urandom});

    // Fill of line 5.
    txn(0, 1'b1, 16'h0028, 64'h1122334455667788);
    txn(0, 1'b0, 16'h0028, 64'h0);
    chk("fill value", last_rd[0], 64'h1122334455667788);
    txn(0, 1'b1, 16'h0200, 64'h0123456789ABCDEF);

    // Write then read of line 32 via a different offset.
    txn(0, 1'b1, 16'h0100, 64'hDEADBEEFCAFEF00D);
    txn(0, 1'b0, 16'h0107, 64'h0);
    chk("write-then-read", last_rd[0], 64'hDEADBEEFCAFEF00D);

    // Back-to-back fills with pedirData held: line 5 then line 64.
    @(negedge clk);
    ped[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h0028;
    @(posedge clk); #1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 4)  last_rd[0] = mdl[0][5];
      if (k == 10) last_rd[0] = mdl[0][64];
      chk($sformatf("b2b busy k%0d", k), 64'(bsy[0]), 64'(k != 5 && k != 11));
      chk($sformatf("b2b dataComplete k%0d", k), 64'(dc[0]), 64'(k == 4 || k == 10));
      chk($sformatf("b2b writeComplete k%0d", k), 64'(wc[0]), 64'h0);
      chk($sformatf("b2b dataIn k%0d", k), din[0], last_rd[0]);
      if (k == 4) addr[0] = 16'h0200;
      if (k == 6) begin ped[0] = 1'b0; wr[0] = 1'b1; addr[0] = 16'hFFFF; end
    end

    // Reset while a write to line 32 sits in WR_WAIT with counter 2.
    @(negedge clk);
    ped[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0100; wdat[0] = 64'hBAD0BAD0BAD0BAD0;
    @(posedge clk); #1;
    ped[0] = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset busy", 64'(bsy[0]), 64'h1);
    rst = 1'b0;
    #1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    chk("mid-reset dataIn", din[0], 64'h0);
    chk("mid-reset busy", 64'(bsy[0]), 64'h0);
    chk("mid-reset writeComplete", 64'(wc[0]), 64'h0);
    chk("mid-reset dataComplete", 64'(dc[0]), 64'h0);
    repeat (3) begin
      @(negedge clk);
      chk("in-reset writeComplete", 64'(wc[0]), 64'h0);
      chk("in-reset busy", 64'(bsy[0]), 64'h0);
    end
    rst = 1'b1;
    txn(0, 1'b0, 16'h0100, 64'h0);
    chk("line kept after reset", last_rd[0], 64'hDEADBEEFCAFEF00D);

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      d = {$urandom, $urandom};
      txn(0, 1'($urandom_range(0, 1)), a, d);
    end

    // LAT=1 instance: aliasing of 0x0008 and 0x0408 onto line 1.
    txn(1, 1'b1, 16'h0008, 64'hA5A5A5A55A5A5A5A);
    txn(1, 1'b0, 16'h0408, 64'h0);
    chk("alias read", last_rd[1], 64'hA5A5A5A55A5A5A5A);
    for (int i = 0; i < 12; i++) begin
      a = {6'($urandom), 7'd1, 3'($urandom)};
      d = {$urandom, $urandom};
      txn(1, 1'($urandom_range(0, 1)), a, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
